// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_ctrl_pkg: shared encodings for the control pipeline and hazards.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package riscv_ctrl_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/control_pipeline_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_pipeline_if: decode bundle, ALU flags and pipeline controls.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface control_pipeline_if #(
  parameter int REG_W  = 5,
  parameter int ALUC_W = 3
);
  logic              RegWriteD;
  logic [1:0]        ResultSrcD;
  logic              MemWriteD;
  logic              JumpD;
  logic              BranchD;
  logic [ALUC_W-1:0] ALUControlD;
  logic              ALUSrcD;
  logic [2:0]        funct3D;
  logic [REG_W-1:0]  Rs1D;
  logic [REG_W-1:0]  Rs2D;
  logic [REG_W-1:0]  RdD;
  logic              ZeroE;
  logic              LtE;
  logic              LtuE;

  logic [ALUC_W-1:0] ALUControlE;
  logic              ALUSrcE;
  logic              PCSrcE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              MemWriteM;
  logic              RegWriteW;
  logic [1:0]        ResultSrcW;
  logic [REG_W-1:0]  RdW;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, funct3D, Rs1D, Rs2D, RdD, ZeroE, LtE, LtuE,
    input  ALUControlE, ALUSrcE, PCSrcE, ForwardAE, ForwardBE, MemWriteM,
           RegWriteW, ResultSrcW, RdW, StallF, StallD, FlushD, FlushE
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, funct3D, Rs1D, Rs2D, RdD, ZeroE, LtE, LtuE,
    output ALUControlE, ALUSrcE, PCSrcE, ForwardAE, ForwardBE, MemWriteM,
           RegWriteW, ResultSrcW, RdW, StallF, StallD, FlushD, FlushE
  );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_unit: load-use stall, operand forwarding selects, flush controls. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  wire logic [1:0]       ResultSrcE_i,
  input  wire logic [REG_W-1:0] RdE_i,
  input  wire logic [REG_W-1:0] Rs1E_i,
  input  wire logic [REG_W-1:0] Rs2E_i,
  input  wire logic [REG_W-1:0] Rs1D_i,
  input  wire logic [REG_W-1:0] Rs2D_i,
  input  wire logic             RegWriteM_i,
  input  wire logic [REG_W-1:0] RdM_i,
  input  wire logic             RegWriteW_i,
  input  wire logic [REG_W-1:0] RdW_i,
  input  wire logic             PCSrcE_i,
  output logic [1:0]            ForwardAE_o,
  output logic [1:0]            ForwardBE_o,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o
);

  logic lw_stall;

  // The younger writer (M) wins over W; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             wr_m,
    input logic [REG_W-1:0] rd_m,
    input logic             wr_w,
    input logic [REG_W-1:0] rd_w,
    input logic [REG_W-1:0] rs
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  assign lw_stall = (ResultSrcE_i == RES_MEM) && (RdE_i != '0) &&
                    ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));

  assign ForwardAE_o = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs1E_i);
  assign ForwardBE_o = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs2E_i);

  assign StallF_o = lw_stall;
  assign StallD_o = lw_stall;
  assign FlushD_o = PCSrcE_i;
  assign FlushE_o = lw_stall | PCSrcE_i;

endmodule
`default_nettype wire

// File: rtl/control_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_pipeline: E/M/W control registers, branch resolution in E and    |
// | hazard control. BRANCH_CMP_EN adds blt/bge/bltu/bgeu.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module control_pipeline
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int ALUC_W = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  control_pipeline_if.slave bus
);

  logic              regwrite_e_q,  regwrite_e_d;
  logic [1:0]        resultsrc_e_q, resultsrc_e_d;
  logic              memwrite_e_q,  memwrite_e_d;
  logic              jump_e_q,      jump_e_d;
  logic              branch_e_q,    branch_e_d;
  logic [ALUC_W-1:0] aluctrl_e_q,   aluctrl_e_d;
  logic              alusrc_e_q,    alusrc_e_d;
  logic [2:0]        funct3_e_q,    funct3_e_d;
  logic [REG_W-1:0]  rs1_e_q,       rs1_e_d;
  logic [REG_W-1:0]  rs2_e_q,       rs2_e_d;
  logic [REG_W-1:0]  rd_e_q,        rd_e_d;

  logic              regwrite_m_q;
  logic [1:0]        resultsrc_m_q;
  logic              memwrite_m_q;
  logic [REG_W-1:0]  rd_m_q;

  logic              regwrite_w_q;
  logic [1:0]        resultsrc_w_q;
  logic [REG_W-1:0]  rd_w_q;

  logic              taken;
  logic              pcsrc_e;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  always_comb begin
    taken = 1'b0;
    case (funct3_e_q)
      F3_BEQ:  taken = bus.ZeroE;
      F3_BNE:  taken = ~bus.ZeroE;
`ifdef BRANCH_CMP_EN
      F3_BLT:  taken = bus.LtE;
      F3_BGE:  taken = ~bus.LtE;
      F3_BLTU: taken = bus.LtuE;
      F3_BGEU: taken = ~bus.LtuE;
`else
      F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: taken = 1'b0;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef BRANCH_CMP_EN
  logic unused_flags;
  assign unused_flags = bus.LtE ^ bus.LtuE;
`endif

  assign pcsrc_e = jump_e_q | (branch_e_q & taken);

  hazard_unit #(
    .REG_W (REG_W)
  ) u_hazard (
    .ResultSrcE_i (resultsrc_e_q),
    .RdE_i        (rd_e_q),
    .Rs1E_i       (rs1_e_q),
    .Rs2E_i       (rs2_e_q),
    .Rs1D_i       (bus.Rs1D),
    .Rs2D_i       (bus.Rs2D),
    .RegWriteM_i  (regwrite_m_q),
    .RdM_i        (rd_m_q),
    .RegWriteW_i  (regwrite_w_q),
    .RdW_i        (rd_w_q),
    .PCSrcE_i     (pcsrc_e),
    .ForwardAE_o  (fwd_a),
    .ForwardBE_o  (fwd_b),
    .StallF_o     (stall_f),
    .StallD_o     (stall_d),
    .FlushD_o     (flush_d),
    .FlushE_o     (flush_e)
  );

  // A flushed E slot becomes an all-zero bubble: no write, no branch, no jump.
  always_comb begin
    regwrite_e_d  = bus.RegWriteD;
    resultsrc_e_d = bus.ResultSrcD;
    memwrite_e_d  = bus.MemWriteD;
    jump_e_d      = bus.JumpD;
    branch_e_d    = bus.BranchD;
    aluctrl_e_d   = bus.ALUControlD;
    alusrc_e_d    = bus.ALUSrcD;
    funct3_e_d    = bus.funct3D;
    rs1_e_d       = bus.Rs1D;
    rs2_e_d       = bus.Rs2D;
    rd_e_d        = bus.RdD;
    if (flush_e) begin
      regwrite_e_d  = 1'b0;
      resultsrc_e_d = RES_ALU;
      memwrite_e_d  = 1'b0;
      jump_e_d      = 1'b0;
      branch_e_d    = 1'b0;
      aluctrl_e_d   = '0;
      alusrc_e_d    = 1'b0;
      funct3_e_d    = '0;
      rs1_e_d       = '0;
      rs2_e_d       = '0;
      rd_e_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_e_q  <= 1'b0;
      resultsrc_e_q <= RES_ALU;
      memwrite_e_q  <= 1'b0;
      jump_e_q      <= 1'b0;
      branch_e_q    <= 1'b0;
      aluctrl_e_q   <= '0;
      alusrc_e_q    <= 1'b0;
      funct3_e_q    <= '0;
      rs1_e_q       <= '0;
      rs2_e_q       <= '0;
      rd_e_q        <= '0;
      regwrite_m_q  <= 1'b0;
      resultsrc_m_q <= RES_ALU;
      memwrite_m_q  <= 1'b0;
      rd_m_q        <= '0;
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= RES_ALU;
      rd_w_q        <= '0;
    end else begin
      regwrite_e_q  <= regwrite_e_d;
      resultsrc_e_q <= resultsrc_e_d;
      memwrite_e_q  <= memwrite_e_d;
      jump_e_q      <= jump_e_d;
      branch_e_q    <= branch_e_d;
      aluctrl_e_q   <= aluctrl_e_d;
      alusrc_e_q    <= alusrc_e_d;
      funct3_e_q    <= funct3_e_d;
      rs1_e_q       <= rs1_e_d;
      rs2_e_q       <= rs2_e_d;
      rd_e_q        <= rd_e_d;
      regwrite_m_q  <= regwrite_e_q;
      resultsrc_m_q <= resultsrc_e_q;
      memwrite_m_q  <= memwrite_e_q;
      rd_m_q        <= rd_e_q;
      regwrite_w_q  <= regwrite_m_q;
      resultsrc_w_q <= resultsrc_m_q;
      rd_w_q        <= rd_m_q;
    end
  end

  assign bus.ALUControlE = aluctrl_e_q;
  assign bus.ALUSrcE     = alusrc_e_q;
  assign bus.PCSrcE      = pcsrc_e;
  assign bus.ForwardAE   = fwd_a;
  assign bus.ForwardBE   = fwd_b;
  assign bus.MemWriteM   = memwrite_m_q;
  assign bus.RegWriteW   = regwrite_w_q;
  assign bus.ResultSrcW  = resultsrc_w_q;
  assign bus.RdW         = rd_w_q;
  assign bus.StallF      = stall_f;
  assign bus.StallD      = stall_d;
  assign bus.FlushD      = flush_d;
  assign bus.FlushE      = flush_e;

endmodule
`default_nettype wire

// File: tb/tb_control_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_control_pipeline: directed and random checks of control_pipeline.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_control_pipeline;

  localparam int REG_W  = 5;
  localparam int ALUC_W = 3;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic [2:0] aluc;
    logic       alusrc;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctl_t;

  typedef struct packed {
    logic [2:0] aluc_e;
    logic       alusrc_e;
    logic       pcsrc;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       memwrite_m;
    logic       regwrite_w;
    logic [1:0] ressrc_w;
    logic [4:0] rd_w;
    logic       stallf;
    logic       stalld;
    logic       flushd;
    logic       flushe;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  ctl_t pipe [3];   // instructions resident in E, M, W

  always #5 clk = ~clk;

  control_pipeline_if #(.REG_W(REG_W), .ALUC_W(ALUC_W)) bus ();

  control_pipeline #(.REG_W(REG_W), .ALUC_W(ALUC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive(input ctl_t c, input logic z, input logic lt, input logic ltu);
    bus.RegWriteD   = c.regwrite;
    bus.ResultSrcD  = c.resultsrc;
    bus.MemWriteD   = c.memwrite;
    bus.JumpD       = c.jump;
    bus.BranchD     = c.branch;
    bus.ALUControlD = c.aluc;
    bus.ALUSrcD     = c.alusrc;
    bus.funct3D     = c.f3;
    bus.Rs1D        = c.rs1;
    bus.Rs2D        = c.rs2;
    bus.RdD         = c.rd;
    bus.ZeroE       = z;
    bus.LtE         = lt;
    bus.LtuE        = ltu;
  endtask

  function automatic ctl_t d_bundle();
    ctl_t c;
    c.regwrite = bus.RegWriteD;  c.resultsrc = bus.ResultSrcD;
    c.memwrite = bus.MemWriteD;  c.jump = bus.JumpD;  c.branch = bus.BranchD;
    c.aluc = bus.ALUControlD;    c.alusrc = bus.ALUSrcD;  c.f3 = bus.funct3D;
    c.rs1 = bus.Rs1D;  c.rs2 = bus.Rs2D;  c.rd = bus.RdD;
    return c;
  endfunction

  function automatic logic model_taken();
    case (pipe[0].f3)
      3'd0: return bus.ZeroE;
      3'd1: return !bus.ZeroE;
`ifdef BRANCH_CMP_EN
      3'd4: return bus.LtE;
      3'd5: return !bus.LtE;
      3'd6: return bus.LtuE;
      3'd7: return !bus.LtuE;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_redirect();
    return pipe[0].jump || (pipe[0].branch && model_taken());
  endfunction

  function automatic logic model_lw();
    return (pipe[0].resultsrc == 2'd1) && (pipe[0].rd != 0) &&
           (bus.Rs1D == pipe[0].rd || bus.Rs2D == pipe[0].rd);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs != 0 && pipe[1].regwrite && pipe[1].rd == rs) return 2'd2;
    if (rs != 0 && pipe[2].regwrite && pipe[2].rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic out_t exp_out();
    out_t o;
    o.aluc_e     = pipe[0].aluc;
    o.alusrc_e   = pipe[0].alusrc;
    o.pcsrc      = model_redirect();
    o.fa         = model_fwd(pipe[0].rs1);
    o.fb         = model_fwd(pipe[0].rs2);
    o.memwrite_m = pipe[1].memwrite;
    o.regwrite_w = pipe[2].regwrite;
    o.ressrc_w   = pipe[2].resultsrc;
    o.rd_w       = pipe[2].rd;
    o.stallf     = model_lw();
    o.stalld     = model_lw();
    o.flushd     = model_redirect();
    o.flushe     = model_lw() || model_redirect();
    return o;
  endfunction

  function automatic out_t act_out();
    return {bus.ALUControlE, bus.ALUSrcE, bus.PCSrcE, bus.ForwardAE, bus.ForwardBE,
            bus.MemWriteM, bus.RegWriteW, bus.ResultSrcW, bus.RdW,
            bus.StallF, bus.StallD, bus.FlushD, bus.FlushE};
  endfunction

  // Advance one clock edge, moving the model's instructions down the pipe.
  task automatic tick();
    ctl_t nxt;
    logic r;
    r   = rst;
    nxt = (model_lw() || model_redirect()) ? ctl_t'('0) : d_bundle();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
    #1;
  endtask

  task automatic test_reset();
    ctl_t c;
    out_t act, exp;
    rst = 1'b1;
    c = '0; c.regwrite = 1'b1; c.memwrite = 1'b1; c.rd = 5'd4; c.aluc = 3'd6; c.alusrc = 1'b1;
    drive(c, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      act = act_out(); n_run++;
      if (act !== '0) begin
        n_fail++; $display("FAIL reset_zero act=%h exp=0", act);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      act = act_out(); exp = exp_out(); n_run++;
      if (act.regwrite_w !== (k == 3) || act !== exp) begin
        n_fail++; $display("FAIL reset_latency edge=%0d act=%h exp=%h", k, act, exp);
      end
    end
  endtask

  task automatic test_forward();
    ctl_t a, b, c;
    out_t act, exp;
    logic [1:0] want;
    for (int v = 0; v < 3; v++) begin
      a = '0; a.regwrite = 1'b1; a.rd = (v == 2) ? 5'd0 : 5'd5; a.aluc = 3'($urandom);
      b = (v == 1) ? ctl_t'('0) : a;
      c = '0; c.regwrite = 1'b1; c.rs1 = 5'd5; c.rs2 = 5'd20; c.rd = 5'd6;
      want = (v == 0) ? 2'b10 : (v == 1) ? 2'b01 : 2'b00;
      drive(a, 1'b0, 1'b0, 1'b0); tick();
      drive(b, 1'b0, 1'b0, 1'b0); tick();
      drive(c, 1'b0, 1'b0, 1'b0); tick();
      drive('0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      act = act_out(); exp = exp_out(); n_run++;
      if (act.fa !== want || act !== exp) begin
        n_fail++; $display("FAIL forward_a v=%0d act=%h exp=%h fa=%b want=%b", v, act, exp, act.fa, want);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    ctl_t lw, x;
    out_t act, exp;
    lw = '0; lw.regwrite = 1'b1; lw.resultsrc = 2'b01; lw.rd = 5'd7; lw.rs1 = 5'd1;
    x  = '0; x.regwrite = 1'b1; x.rd = 5'd8; x.rs1 = 5'd2; x.rs2 = 5'd7; x.aluc = 3'd2;
    drive(lw, 1'b0, 1'b0, 1'b0); tick();
    drive(x, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    act = act_out(); exp = exp_out(); n_run++;
    if ({act.stallf, act.stalld, act.flushd, act.flushe} !== 4'b1101 || act !== exp) begin
      n_fail++; $display("FAIL loaduse_stall act=%h exp=%h", act, exp);
    end
    tick();
    @(negedge clk);
    act = act_out(); exp = exp_out(); n_run++;
    if ({act.stallf, act.stalld, act.flushe} !== 3'b000 || act.aluc_e !== 3'd0 || act !== exp) begin
      n_fail++; $display("FAIL loaduse_release act=%h exp=%h", act, exp);
    end
    tick();
    drive('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    act = act_out(); exp = exp_out(); n_run++;
    if (act.fb !== 2'b01 || act !== exp) begin
      n_fail++; $display("FAIL loaduse_fwd_b act=%h exp=%h", act, exp);
    end
    tick();
  endtask

  task automatic test_branch();
    ctl_t br, y;
    out_t act, exp;
    logic want;
    for (int v = 0; v < 3; v++) begin
      br = '0; br.aluc = 3'd1; br.rs1 = 5'd1; br.rs2 = 5'd2;
      if (v == 2) begin
        br.jump = 1'b1; br.regwrite = 1'b1; br.resultsrc = 2'b10; br.rd = 5'd1; br.f3 = 3'($urandom);
      end else begin
        br.branch = 1'b1;
      end
      y = '0; y.regwrite = 1'b1; y.rd = 5'd9; y.rs1 = 5'd3; y.rs2 = 5'd4; y.aluc = 3'b101; y.alusrc = 1'b1;
      want = (v != 1);
      drive(br, 1'b0, 1'b0, 1'b0); tick();
      drive(y, (v == 0), 1'($urandom), 1'($urandom));
      @(negedge clk);
      act = act_out(); exp = exp_out(); n_run++;
      if ({act.pcsrc, act.flushd, act.flushe} !== {3{want}} || act !== exp) begin
        n_fail++; $display("FAIL branch_redirect v=%0d act=%h exp=%h", v, act, exp);
      end
      tick();
      drive('0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      act = act_out(); exp = exp_out(); n_run++;
      if (act.aluc_e !== (want ? 3'd0 : 3'b101) || act !== exp) begin
        n_fail++; $display("FAIL branch_bubble v=%0d act=%h exp=%h", v, act, exp);
      end
      tick();
    end
  endtask

  task automatic test_branch_cmp();
    logic [2:0] f3s  [5] = '{3'b100, 3'b111, 3'b101, 3'b110, 3'b010};
    logic       lts  [5] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    logic       ltus [5] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
`ifdef BRANCH_CMP_EN
    logic       want [5] = '{1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
`else
    logic       want [5] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
`endif
    ctl_t br;
    out_t act, exp;
    for (int i = 0; i < 5; i++) begin
      br = '0; br.branch = 1'b1; br.f3 = f3s[i]; br.rs1 = 5'd10; br.rs2 = 5'd11;
      drive(br, 1'b0, 1'b0, 1'b0); tick();
      drive('0, 1'($urandom), lts[i], ltus[i]);
      @(negedge clk);
      act = act_out(); exp = exp_out(); n_run++;
      if (act.pcsrc !== want[i] || act !== exp) begin
        n_fail++; $display("FAIL branch_cmp f3=%b act=%h exp=%h", f3s[i], act, exp);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    ctl_t j, z;
    out_t act, exp;
    j = '0; j.jump = 1'b1; j.regwrite = 1'b1; j.resultsrc = 2'b01; j.rd = 5'd7; j.aluc = 3'd4;
    z = '0; z.regwrite = 1'b1; z.rs1 = 5'd7; z.rd = 5'd10; z.aluc = 3'b011;
    drive(j, 1'b0, 1'b0, 1'b0); tick();
    drive(z, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    act = act_out(); exp = exp_out(); n_run++;
    if ({act.stallf, act.stalld, act.flushd, act.flushe} !== 4'b1111 || act !== exp) begin
      n_fail++; $display("FAIL simul_hazard act=%h exp=%h", act, exp);
    end
    tick();
    drive('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    act = act_out(); exp = exp_out(); n_run++;
    if (act.aluc_e !== 3'd0 || act !== exp) begin
      n_fail++; $display("FAIL simul_bubble act=%h exp=%h", act, exp);
    end
    tick();
    drive(j, 1'b0, 1'b0, 1'b0); tick();
    drive(z, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    act = act_out(); n_run++;
    if (act !== '0) begin
      n_fail++; $display("FAIL simul_reset act=%h exp=0", act);
    end
    tick();
  endtask

  task automatic test_random();
    ctl_t c;
    out_t act, exp;
    for (int n = 0; n < 400; n++) begin
      c.regwrite  = 1'($urandom);
      c.resultsrc = 2'($urandom_range(0, 2));
      c.memwrite  = 1'($urandom);
      c.jump      = ($urandom_range(0, 7) == 0);
      c.branch    = ($urandom_range(0, 3) == 0);
      c.aluc      = 3'($urandom);
      c.alusrc    = 1'($urandom);
      c.f3        = 3'($urandom);
      c.rs1       = 5'($urandom_range(0, 3));
      c.rs2       = 5'($urandom_range(0, 3));
      c.rd        = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 39) == 0);
      drive(c, 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      act = act_out(); exp = exp_out(); n_run++;
      if (act !== exp) begin
        n_fail++; $display("FAIL random cyc=%0d act=%h exp=%h", n, act, exp);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    rst = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_branch_cmp();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
